// File: rtl/ccu_snoop_sequencer.sv
// Coherent snoop sequencer: fans one request out as AC snoops to every other core and merges the CR replies.
// Optional snoop timeout is compiled in by defining CCU_SNOOP_TIMEOUT_EN.
//
// state    | meaning
// S_IDLE   | ready to accept a new coherent request
// S_SNOOP  | issuing AC snoops and collecting CR responses
// S_RESULT | merged response presented until consumed
module ccu_snoop_sequencer #(
  parameter int NB_CORES  = 4,
  parameter int AddrWidth = 64,
  parameter int Timeout   = 256
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [$clog2(NB_CORES)-1:0] req_initiator_i,
  input  logic [AddrWidth-1:0]        req_addr_i,
  input  logic [3:0]                  req_snoop_i,
  output logic [NB_CORES-1:0]         ac_valid_o,
  input  logic [NB_CORES-1:0]         ac_ready_i,
  output logic [AddrWidth-1:0]        ac_addr_o,
  output logic [3:0]                  ac_snoop_o,
  input  logic [NB_CORES-1:0]         cr_valid_i,
  output logic [NB_CORES-1:0]         cr_ready_o,
  input  logic [NB_CORES*5-1:0]       cr_resp_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic                        rsp_data_o,
  output logic                        rsp_dirty_o,
  output logic                        rsp_shared_o,
  output logic                        rsp_error_o,
  output logic [$clog2(NB_CORES)-1:0] rsp_src_o
);

  localparam int IdxW = $clog2(NB_CORES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SNOOP  = 2'd1;
  localparam logic [1:0] S_RESULT = 2'd2;

  logic [1:0]           state_q;
  logic [NB_CORES-1:0]  ac_pend_q;
  logic [NB_CORES-1:0]  cr_pend_q;
  logic [NB_CORES-1:0]  dt_mask_q;
  logic                 dirty_q;
  logic                 shared_q;
  logic                 error_q;
  logic [AddrWidth-1:0] addr_q;
  logic [3:0]           snoop_q;

  logic [NB_CORES-1:0]  target_mask;
  logic [NB_CORES-1:0]  ac_hs;
  logic [NB_CORES-1:0]  cr_hs;
  logic [NB_CORES-1:0]  ac_pend_nxt;
  logic [NB_CORES-1:0]  cr_pend_nxt;
  logic [NB_CORES-1:0]  dt_new;
  logic                 err_new;
  logic                 dirty_new;
  logic                 shared_new;
  logic                 snoop_done;
  logic                 tmo_hit;
  logic                 in_result;
  logic [IdxW-1:0]      src;
  logic [NB_CORES-1:0]  unused_was_unique;

  // An out-of-range initiator matches no index, so every core is snooped.
  always_comb begin
    target_mask = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      target_mask[i] = (req_initiator_i != IdxW'(i));
    end
  end

  assign ac_hs       = ac_pend_q & ac_ready_i;
  assign cr_hs       = cr_pend_q & cr_valid_i;
  assign ac_pend_nxt = ac_pend_q & ~ac_hs;
  // A core becomes CR-eligible only from the cycle after its AC handshake.
  assign cr_pend_nxt = (cr_pend_q & ~cr_hs) | ac_hs;
  assign snoop_done  = (ac_pend_nxt == '0) && (cr_pend_nxt == '0);

  always_comb begin
    dt_new            = '0;
    err_new           = 1'b0;
    dirty_new         = 1'b0;
    shared_new        = 1'b0;
    unused_was_unique = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      dt_new[i]            = cr_hs[i] & cr_resp_i[i*5];
      err_new              = err_new    | (cr_hs[i] & cr_resp_i[i*5+1]);
      dirty_new            = dirty_new  | (cr_hs[i] & cr_resp_i[i*5+2]);
      shared_new           = shared_new | (cr_hs[i] & cr_resp_i[i*5+3]);
      unused_was_unique[i] = cr_resp_i[i*5+4];
    end
  end

`ifdef CCU_SNOOP_TIMEOUT_EN
  localparam int CntW = $clog2(Timeout + 1);
  logic [CntW-1:0] tmo_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || (state_q != S_SNOOP)) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign tmo_hit = (state_q == S_SNOOP) && (tmo_cnt_q == CntW'(Timeout - 1));
`else
  localparam int unused_timeout = Timeout;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      ac_pend_q <= '0;
      cr_pend_q <= '0;
      dt_mask_q <= '0;
      dirty_q   <= 1'b0;
      shared_q  <= 1'b0;
      error_q   <= 1'b0;
      addr_q    <= '0;
      snoop_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            addr_q    <= req_addr_i;
            snoop_q   <= req_snoop_i;
            ac_pend_q <= target_mask;
            cr_pend_q <= '0;
            dt_mask_q <= '0;
            dirty_q   <= 1'b0;
            shared_q  <= 1'b0;
            error_q   <= 1'b0;
            state_q   <= S_SNOOP;
          end
        end
        S_SNOOP: begin
          dt_mask_q <= dt_mask_q | dt_new;
          dirty_q   <= dirty_q | dirty_new;
          shared_q  <= shared_q | shared_new;
          ac_pend_q <= ac_pend_nxt;
          cr_pend_q <= cr_pend_nxt;
          if (snoop_done) begin
            error_q <= error_q | err_new;
            state_q <= S_RESULT;
          end else if (tmo_hit) begin
            error_q   <= 1'b1;
            ac_pend_q <= '0;
            cr_pend_q <= '0;
            state_q   <= S_RESULT;
          end else begin
            error_q <= error_q | err_new;
          end
        end
        S_RESULT: begin
          if (rsp_ready_i) begin
            dt_mask_q <= '0;
            dirty_q   <= 1'b0;
            shared_q  <= 1'b0;
            error_q   <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          ac_pend_q <= '0;
          cr_pend_q <= '0;
        end
      endcase
    end
  end

  // Lowest responding data source wins, independent of arrival order.
  always_comb begin
    src = '0;
    for (int i = NB_CORES - 1; i >= 0; i--) begin
      if (dt_mask_q[i]) src = IdxW'(i);
    end
  end

  assign in_result    = (state_q == S_RESULT);
  assign req_ready_o  = (state_q == S_IDLE);
  assign ac_valid_o   = ac_pend_q;
  assign cr_ready_o   = cr_pend_q;
  assign ac_addr_o    = addr_q;
  assign ac_snoop_o   = snoop_q;
  assign rsp_valid_o  = in_result;
  assign rsp_data_o   = in_result & (|dt_mask_q);
  assign rsp_dirty_o  = in_result & dirty_q;
  assign rsp_shared_o = in_result & shared_q;
  assign rsp_error_o  = in_result & error_q;
  assign rsp_src_o    = in_result ? src : '0;

endmodule

// File: tb/tb_ccu_snoop_sequencer.sv
// Self-checking bench for ccu_snoop_sequencer: directed scenarios plus randomized transactions
// against a timeline model (cycle numbers derived from per-core AC/CR delays).
module tb_ccu_snoop_sequencer;

  localparam int NB    = 4;
  localparam int IW    = 2;
  localparam int AW    = 64;
  localparam int RW    = NB * 5;
  localparam int TMO   = 16;
  localparam int NEVER = 100000;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [IW-1:0] req_initiator_i;
  logic [AW-1:0] req_addr_i;
  logic [3:0]    req_snoop_i;
  logic [NB-1:0] ac_valid_o;
  logic [NB-1:0] ac_ready_i;
  logic [AW-1:0] ac_addr_o;
  logic [3:0]    ac_snoop_o;
  logic [NB-1:0] cr_valid_i;
  logic [NB-1:0] cr_ready_o;
  logic [RW-1:0] cr_resp_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic          rsp_data_o;
  logic          rsp_dirty_o;
  logic          rsp_shared_o;
  logic          rsp_error_o;
  logic [IW-1:0] rsp_src_o;

  ccu_snoop_sequencer #(.NB_CORES(NB), .AddrWidth(AW), .Timeout(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_initiator_i(req_initiator_i), .req_addr_i(req_addr_i), .req_snoop_i(req_snoop_i),
    .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i), .ac_addr_o(ac_addr_o), .ac_snoop_o(ac_snoop_o),
    .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_dirty_o(rsp_dirty_o), .rsp_shared_o(rsp_shared_o),
    .rsp_error_o(rsp_error_o), .rsp_src_o(rsp_src_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction description: a_d = cycle of AC handshake, c_d = cycle of CR handshake,
  // both counted from the acceptance cycle (t=0); k_hold = cycles rsp_ready_i is held low.
  logic [NB-1:0] tgt;
  int            a_d [NB];
  int            c_d [NB];
  logic [4:0]    rs  [NB];
  int            k_hold;
  int            abort_at;
  int            t_r;
  logic [AW-1:0] taddr;
  logic [3:0]    tsnoop;
  logic [IW-1:0] tinit;
  logic          m_data, m_dirty, m_shared, m_error;
  logic [IW-1:0] m_src;

  int t = 0;
  bit in_txn = 1'b0;
  bit chk_en = 1'b0;

  int            obs_rt;
  logic [3:0]    obs_flags;
  logic [IW-1:0] obs_src;
  logic [NB-1:0] obs_ac1;
  int            obs_ac2;

  logic [NB-1:0] e_ac, e_cr;
  logic          e_rq, e_rv;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d actual=%0h expected=%0h", nm, t, act, exp);
    end
  endtask

  // Result cycle and merged response from the per-core schedule.
  function automatic void model_setup();
    int maxc;
    bit timed;
    maxc  = 0;
    timed = 1'b0;
    for (int i = 0; i < NB; i++) if (tgt[i] && c_d[i] > maxc) maxc = c_d[i];
    t_r = maxc + 1;
`ifdef CCU_SNOOP_TIMEOUT_EN
    if (maxc > TMO) begin
      t_r   = TMO + 1;
      timed = 1'b1;
    end
`endif
    m_data = 1'b0; m_dirty = 1'b0; m_shared = 1'b0; m_error = timed; m_src = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (tgt[i] && c_d[i] < t_r) begin
        m_data   = m_data   | rs[i][0];
        m_error  = m_error  | rs[i][1];
        m_dirty  = m_dirty  | rs[i][2];
        m_shared = m_shared | rs[i][3];
        if (rs[i][0]) m_src = IW'(i);
      end
    end
  endfunction

  task automatic drive_cycle();
    rst_i           = 1'b0;
    req_valid_i     = 1'b0;
    req_initiator_i = IW'($urandom);
    req_addr_i      = {$urandom, $urandom};
    req_snoop_i     = 4'($urandom);
    ac_ready_i      = NB'($urandom);
    cr_valid_i      = NB'($urandom);
    cr_resp_i       = RW'($urandom);
    rsp_ready_i     = 1'($urandom);
    if (in_txn) begin
      if (t == 0) begin
        req_valid_i     = 1'b1;
        req_initiator_i = tinit;
        req_addr_i      = taddr;
        req_snoop_i     = tsnoop;
      end else if (abort_at < 0) begin
        req_valid_i = 1'($urandom);
      end
      for (int i = 0; i < NB; i++) begin
        if (tgt[i]) begin
          if (t >= 1 && t < a_d[i]) ac_ready_i[i] = 1'b0;
          else if (t == a_d[i]) ac_ready_i[i] = 1'b1;
          if (t > a_d[i] && t < c_d[i]) cr_valid_i[i] = 1'b0;
          else if (t == c_d[i]) begin
            cr_valid_i[i]       = 1'b1;
            cr_resp_i[i*5 +: 5] = rs[i];
          end
        end
      end
      if (t >= t_r && t < t_r + k_hold) rsp_ready_i = 1'b0;
      else if (t == t_r + k_hold) rsp_ready_i = 1'b1;
      if (t == abort_at) rst_i = 1'b1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk_i); #1;
      in_txn = 1'b0;
      drive_cycle();
    end
  endtask

  task automatic run_txn();
    int last;
    model_setup();
    obs_rt = -1; obs_flags = '0; obs_src = '0; obs_ac1 = '0; obs_ac2 = 0;
    last = (abort_at >= 0) ? abort_at + 3 : t_r + k_hold;
    for (int tt = 0; tt <= last; tt++) begin
      @(posedge clk_i); #1;
      in_txn = 1'b1;
      t      = tt;
      drive_cycle();
    end
    @(negedge clk_i); #1;
  endtask

  task automatic rand_txn();
    tinit  = IW'($urandom);
    tgt    = '1;
    tgt[tinit] = 1'b0;
    taddr  = {$urandom, $urandom};
    tsnoop = 4'($urandom);
    for (int i = 0; i < NB; i++) begin
      a_d[i] = 1 + $urandom_range(0, 3);
      c_d[i] = a_d[i] + 1 + $urandom_range(0, 3);
      rs[i]  = 5'($urandom);
    end
    k_hold   = $urandom_range(0, 3);
    abort_at = -1;
    model_setup();
    if ($urandom_range(0, 7) == 0) abort_at = $urandom_range(0, t_r - 1);
  endtask

  task automatic set_simple(input logic [IW-1:0] init);
    tinit  = init;
    tgt    = '1;
    tgt[init] = 1'b0;
    taddr  = {$urandom, $urandom};
    tsnoop = 4'($urandom);
    for (int i = 0; i < NB; i++) begin
      a_d[i] = 1;
      c_d[i] = 2;
      rs[i]  = 5'b0;
    end
    k_hold   = 0;
    abort_at = -1;
  endtask

  // Per-cycle comparison against the timeline model.
  always @(negedge clk_i) begin
    if (chk_en) begin
      if (!in_txn || (abort_at >= 0 && t > abort_at)) begin
        e_rq = 1'b1; e_ac = '0; e_cr = '0; e_rv = 1'b0;
      end else begin
        e_rq = (t == 0);
        for (int i = 0; i < NB; i++) begin
          e_ac[i] = tgt[i] && t >= 1 && t <= a_d[i] && t < t_r;
          e_cr[i] = tgt[i] && t > a_d[i] && t <= c_d[i] && t < t_r;
        end
        e_rv = (t >= t_r) && (t <= t_r + k_hold);
        if (t >= 1 && t <= t_r + k_hold) begin
          chk("ac_addr", ac_addr_o, taddr);
          chk("ac_snoop", 64'(ac_snoop_o), 64'(tsnoop));
        end
        if (e_rv) begin
          chk("rsp_flags", 64'({rsp_data_o, rsp_dirty_o, rsp_shared_o, rsp_error_o}),
              64'({m_data, m_dirty, m_shared, m_error}));
          chk("rsp_src", 64'(rsp_src_o), 64'(m_src));
        end
      end
      chk("req_ready", 64'(req_ready_o), 64'(e_rq));
      chk("ac_valid", 64'(ac_valid_o), 64'(e_ac));
      chk("cr_ready", 64'(cr_ready_o), 64'(e_cr));
      chk("rsp_valid", 64'(rsp_valid_o), 64'(e_rv));
      if (in_txn) begin
        if (t == 1) obs_ac1 = ac_valid_o;
        if (ac_valid_o[2]) obs_ac2++;
        if (rsp_valid_o && obs_rt < 0) begin
          obs_rt    = t;
          obs_flags = {rsp_data_o, rsp_dirty_o, rsp_shared_o, rsp_error_o};
          obs_src   = rsp_src_o;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0d", t);
    $fatal(1, "watchdog");
  end

  initial begin
    in_txn = 1'b0;
    drive_cycle();
    rst_i = 1'b1;
    @(posedge clk_i); @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_req_ready", 64'(req_ready_o), 64'd1);
    chk("rst_ac_valid", 64'(ac_valid_o), 64'd0);
    chk("rst_cr_ready", 64'(cr_ready_o), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_rsp_fields", 64'({rsp_data_o, rsp_dirty_o, rsp_shared_o, rsp_error_o, rsp_src_o}), 64'd0);
    chk("rst_ac_addr", ac_addr_o, 64'd0);
    chk("rst_ac_snoop", 64'(ac_snoop_o), 64'd0);
    chk_en = 1'b1;
    idle_cycles(2);

    // Zero-latency snoop, initiator 0, simultaneous CRs.
    set_simple(2'd0);
    run_txn();
    chk("lit_ac_t1", 64'(obs_ac1), 64'b1110);
    chk("lit_rsp_cycle", 64'(obs_rt), 64'd3);
    chk("lit_zero_flags", 64'(obs_flags), 64'd0);

    // Out-of-order data responses: lowest index is the source.
    set_simple(2'd0);
    c_d[3] = 2; rs[3] = 5'b00101;
    c_d[2] = 3; rs[2] = 5'b00000;
    c_d[1] = 4; rs[1] = 5'b00001;
    run_txn();
    chk("lit_data_dirty", 64'(obs_flags[3:2]), 64'b11);
    chk("lit_src", 64'(obs_src), 64'd1);
    chk("lit_rsp_cycle2", 64'(obs_rt), 64'd5);

    // Delayed AC ready on core 2 and result back-pressure.
    set_simple(2'd0);
    a_d[2] = 6; c_d[2] = 7; k_hold = 4;
    run_txn();
    chk("lit_ac2_len", 64'(obs_ac2), 64'd6);
    idle_cycles(1);

    // Reset in the middle of SNOOP.
    set_simple(2'd1);
    a_d[2] = 5; c_d[2] = 6; abort_at = 2;
    run_txn();
    chk("lit_abort_no_rsp", 64'(obs_rt), 64'(-1));

    // Core 2 never answers.
    set_simple(2'd0);
    c_d[1] = 2; rs[1] = 5'b00001;
    c_d[3] = 3; rs[3] = 5'b01000;
    c_d[2] = NEVER;
`ifdef CCU_SNOOP_TIMEOUT_EN
    run_txn();
    chk("lit_tmo_cycle", 64'(obs_rt), 64'(TMO + 1));
    chk("lit_tmo_flags", 64'(obs_flags), 64'b1011);
`else
    abort_at = 40;
    run_txn();
    chk("lit_no_tmo", 64'(obs_rt), 64'(-1));
`endif

    for (int n = 0; n < 80; n++) begin
      rand_txn();
      run_txn();
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ccu_snoop_sequencer.md
CCU_SNOOP_SEQUENCER -- requirements
Module: ccu_snoop_sequencer

Interface
REQ-001 SHALL have parameter NB_CORES, default 4, number of coherent cores (legal 2..8).
REQ-002 SHALL have parameter AddrWidth, default 64, snoop address width.
REQ-003 SHALL have parameter Timeout, default 256, snoop timeout in cycles (used only with the timeout feature).
REQ-004 SHALL have ports:
  clk_i  in  1  single clock; all state changes on rising edge
  rst_i  in  1  reset, synchronous, active-high
  req_valid_i  in  1  coherent request valid
  req_ready_o  out  1  request accepted
  req_initiator_i  in  $clog2(NB_CORES)  requesting core index
  req_addr_i  in  AddrWidth  line address
  req_snoop_i  in  4  ACE AC snoop type
  ac_valid_o  out  NB_CORES  per-core snoop address valid
  ac_ready_i  in  NB_CORES  per-core snoop address ready
  ac_addr_o  out  AddrWidth  snoop address, shared by all cores
  ac_snoop_o  out  4  snoop type, shared by all cores
  cr_valid_i  in  NB_CORES  per-core snoop response valid
  cr_ready_o  out  NB_CORES  per-core snoop response ready
  cr_resp_i  in  NB_CORES x 5  per-core CRRESP {WasUnique,IsShared,PassDirty,Error,DataTransfer}
  rsp_valid_o  out  1  merged result valid
  rsp_ready_i  in  1  merged result consumed
  rsp_data_o  out  1  OR of DataTransfer
  rsp_dirty_o  out  1  OR of PassDirty
  rsp_shared_o  out  1  OR of IsShared
  rsp_error_o  out  1  OR of Error, or timeout
  rsp_src_o  out  $clog2(NB_CORES)  lowest core index with DataTransfer=1; 0 if none

Function
REQ-005 SHALL implement FSM IDLE -> SNOOP -> RESULT -> IDLE.
REQ-006 req_ready_o SHALL be 1 only in IDLE; handshake req_valid_i&req_ready_o registers addr, snoop, target mask, then enters SNOOP.
REQ-007 Target mask SHALL be all cores except req_initiator_i; initiator value >= NB_CORES SHALL target all cores.
REQ-008 ac_valid_o[i] SHALL rise the cycle after request acceptance for each target i, and stay high until the cycle ac_valid_o[i]&ac_ready_i[i].
REQ-009 ac_addr_o and ac_snoop_o SHALL hold the registered values from acceptance until return to IDLE.
REQ-010 cr_ready_o[i] SHALL be 1 only when core i's AC handshake completed in an earlier cycle and its CR is not yet received; CR in the same cycle as AC handshake SHALL NOT be accepted.
REQ-011 Each CR handshake SHALL OR its bits into sticky flags; rsp_src_o SHALL take the lowest index with DataTransfer, regardless of arrival order.
REQ-012 SNOOP -> RESULT SHALL occur the cycle after the last outstanding CR handshake; rsp_valid_o high in RESULT.
REQ-013 rsp_* outputs SHALL be stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-014 RESULT -> IDLE on rsp_valid_o&rsp_ready_i; flags cleared; a new request SHALL be acceptable the following cycle (minimum 3-cycle turnaround with zero-latency AC/CR).
REQ-015 Simultaneous CR from several cores in one cycle SHALL all be accepted and merged.
REQ-016 cr_valid_i from non-target or already-responded cores SHALL be ignored (cr_ready_o=0).

Reset
REQ-017 With rst_i=1 at a clock edge: FSM=IDLE, all masks and flags cleared, timeout counter 0.
REQ-018 Reset values: req_ready_o=1, ac_valid_o=0, cr_ready_o=0, rsp_valid_o=0, rsp_* =0, ac_addr_o=0, ac_snoop_o=0.
REQ-019 Reset mid-transaction SHALL abandon it: no result, ac_valid_o low the next cycle.

Configuration
REQ-020 Macro CCU_SNOOP_TIMEOUT_EN defined: counter increments each SNOOP cycle, clears on entry; at Timeout cycles SHALL deassert all ac_valid_o/cr_ready_o, enter RESULT with rsp_error_o=1 and merged flags so far.
REQ-021 Macro undefined: no counter; SNOOP waits indefinitely.

Verification
REQ-022 NB_CORES=4, initiator 0, all ready/CR immediate with resp 0 -> ac_valid_o=4'b1110 for 1 cycle, rsp_valid_o at cycle 3, all flags 0.
REQ-023 Core 3 CR {DataTransfer,PassDirty}, core 1 CR {DataTransfer}, core 3 first -> rsp_data_o=1, rsp_dirty_o=1, rsp_src_o=1.
REQ-024 ac_ready_i[2] delayed 5 cycles -> ac_valid_o[2] held 6 cycles, addr stable, cr_ready_o[2]=0 until after its AC handshake.
REQ-025 rsp_ready_i=0 for 4 cycles -> outputs stable, req_ready_o=0, return to IDLE after handshake.
REQ-026 rst_i pulsed in SNOOP -> next cycle ac_valid_o=0, req_ready_o=1, no rsp_valid_o.
REQ-027 CCU_SNOOP_TIMEOUT_EN, Timeout=16, core 2 never sends CR -> rsp_valid_o with rsp_error_o=1 after 16 SNOOP cycles; without macro, no response.
